alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// Issue side of the ALU interface. Accepts one RV32I/M instruction with its operand values over a
// valid/ready handshake, decodes it into the 4-bit ALU op code, and drives alu_op/alu_a/alu_b to the
// combinational ALU. It captures alu_rd after a fixed latency and presents the result to writeback
// over a second valid/ready handshake. It sits between the register-read stage and writeback.
// PARAMETERS
// DATAWIDTH    32  operand/result width
// MUL_LATENCY  3   cycles op held on ALU before capturing a MUL result; legal range 1..15
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   asynchronous, active-high reset
// in_valid     in   1   instr/operands valid
// in_ready     out  1   block can accept
// in_instr     in   32  RV32 instruction word
// in_rs1_val   in   DW  rs1 register value
// in_rs2_val   in   DW  rs2 register value (ignored for I/U types)
// flush        in   1   synchronous abort of any in-flight op
// alu_op       out  4   to ALU: 0 SLL,1 SRL,2 SRA,3 ADD,4 SUB,5 LUI,6 SLT,7 SLTU,8 XOR,9 OR,A AND,B MUL
// alu_a        out  DW  to ALU operand 1
// alu_b        out  DW  to ALU operand 2
// alu_rd       in   DW  ALU result
// out_valid    out  1   result valid
// out_ready    in   1   writeback accepts
// out_result   out  DW  captured result (0 when illegal)
// out_rd_addr  out  5   in_instr[11:7]
// out_we       out  1   1 unless rd_addr==0 or illegal
// out_illegal  out  1   instruction not decodable
// BEHAVIOUR
// - Reset (async): state IDLE. alu_op=4'h3. alu_a, alu_b, out_result, out_rd_addr, counter = 0.
//   out_valid, out_we, out_illegal = 0. in_ready=1 once reset deasserts.
// - FSM IDLE -> EXEC -> DONE. in_ready = (IDLE) | (DONE & out_ready). Accept = in_valid & in_ready.
// - Decode (registered at accept):
//   - opcode 0110011: f3 000 -> ADD/SUB(f7=0100000)/MUL(f7=0000001); 001 SLL; 010 SLT; 011 SLTU;
//     100 XOR; 101 SRL/SRA(f7=0100000); 110 OR; 111 AND. b=rs2_val.
//     Any other f7 (or MUL with f3!=000) is illegal.
//   - opcode 0010011: same f3 map without SUB/MUL; b=signext(instr[31:20]).
//     SLLI requires f7=0. SRLI/SRAI require f7=0/0100000; shamt is instr[24:20].
//   - opcode 0110111 (LUI): op=LUI, b={instr[31:12],12'h0}, a=0.
//   - All else illegal.
// - Timing: accept edge T loads alu_op/a/b and enters EXEC.
//   - Non-MUL: captures alu_rd at T+1; out_valid=1 from T+1.
//   - MUL: counter loads MUL_LATENCY-1, counts down in EXEC, captures at T+MUL_LATENCY.
//   - Illegal: skips EXEC, enters DONE at T with out_result=0, out_illegal=1, out_we=0.
// - DONE holds all out_* stable while out_valid & !out_ready.
//   - Handshake at edge: with in_valid, accept the new op (back-to-back); without it, go to IDLE.
//   - out_valid drops the cycle after the handshake unless a new illegal op lands directly in DONE.
// - alu_op/a/b hold their last values in IDLE and DONE (no toggling).
// - flush: at the next edge go to IDLE, clear out_valid, and zero the counter.
//   flush beats a simultaneous accept, and the accept is dropped.
// - Reset mid-EXEC: op lost, outputs return to reset values immediately.
// TESTING
// - add x3,x1,x2 (0x002081B3), rs1=5, rs2=7:
//   alu_op=3 at T+0; out_valid at T+1, result 12, rd_addr 3, we=1.
// - srai x5,x1,4 (0x4040D293), rs1=0x80000010: alu_op=2, b=4; result 0xF8000001.
// - mul x6,x1,x2 (0x02208333), 6*7: out_valid exactly MUL_LATENCY cycles after accept; result 42.
// - lui x7,0x12345 (0x123453B7): result 0x12345000.
//   Then out_ready low 4 cycles: out_* stable, in_ready=0.
// - lw (0x00002003) -> out_illegal=1, we=0, result 0.
//   Back-to-back addi x0 with out_ready=1: no bubble, we=0.
// - Assert rst 1 cycle into a MUL: out_valid=0, in_ready=1 after release.
//   flush+in_valid same edge: no accept.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I/M issue controller in front of a combinational ALU
//
// Purpose: accepts one instruction and its operand values, decodes it to a 4-bit ALU op code,
// holds alu_op/alu_a/alu_b steady while the ALU settles, captures alu_rd and offers the result
// to writeback. Illegal instructions go straight to DONE with a zero result.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             issue handshake; in_instr, in_rs1_val, in_rs2_val payload
//   flush                         synchronous abort of any in-flight op
//   alu_op/alu_a/alu_b, alu_rd    to / from the combinational ALU
//   out_valid/out_ready           writeback handshake; out_result, out_rd_addr, out_we, out_illegal
module alu_issue_ctrl #(
  parameter int DATAWIDTH   = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [DATAWIDTH-1:0] in_rs1_val,
  input  logic [DATAWIDTH-1:0] in_rs2_val,
  input  logic                 flush,
  output logic [3:0]           alu_op,
  output logic [DATAWIDTH-1:0] alu_a,
  output logic [DATAWIDTH-1:0] alu_b,
  input  logic [DATAWIDTH-1:0] alu_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_result,
  output logic [4:0]           out_rd_addr,
  output logic                 out_we,
  output logic                 out_illegal
);

  localparam logic [3:0] OP_SLL  = 4'h0, OP_SRL = 4'h1, OP_SRA = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4, OP_LUI = 4'h5, OP_SLT = 4'h6, OP_SLTU = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8, OP_OR  = 4'h9, OP_AND = 4'hA, OP_MUL = 4'hB;
  localparam logic [6:0] OPC_R   = 7'b0110011, OPC_I = 7'b0010011, OPC_LUI = 7'b0110111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           alu_op_q, alu_op_d;
  logic [DATAWIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [DATAWIDTH-1:0] out_result_q, out_result_d;
  logic [4:0]           out_rd_addr_q, out_rd_addr_d;
  logic                 out_valid_q, out_valid_d, out_we_q, out_we_d;
  logic                 out_illegal_q, out_illegal_d;
  logic [3:0]           cnt_q, cnt_d;

  logic [6:0]           opcode, funct7;
  logic [2:0]           funct3;
  logic [DATAWIDTH-1:0] imm_i, imm_u, shamt;
  logic                 dec_illegal, dec_mul;
  logic [3:0]           dec_op;
  logic [DATAWIDTH-1:0] dec_a, dec_b;
  logic                 accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(DATAWIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign shamt  = {{(DATAWIDTH-5){1'b0}}, in_instr[24:20]};
  assign imm_u  = DATAWIDTH'({in_instr[31:12], 12'h000});

  // funct3 -> op for the encodings shared by register and immediate forms
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_op      = base_op(funct3);
    dec_a       = in_rs1_val;
    dec_b       = in_rs2_val;
    case (opcode)
      OPC_R: begin
        case (funct7)
          F7_BASE: dec_op = base_op(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      dec_op = OP_SUB;
            else if (funct3 == 3'b101) dec_op = OP_SRA;
            else                       dec_illegal = 1'b1;
          end
          F7_MUL: begin
            dec_op  = OP_MUL;
            dec_mul = 1'b1;
            if (funct3 != 3'b000) dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_I: begin
        dec_b = imm_i;
        // shift immediates use only the shamt field; the upper bits act as funct7
        if (funct3 == 3'b001) begin
          dec_b = shamt;
          if (funct7 != F7_BASE) dec_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_b = shamt;
          if (funct7 == F7_ALT)       dec_op = OP_SRA;
          else if (funct7 != F7_BASE) dec_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_op = OP_LUI;
        dec_a  = '0;
        dec_b  = imm_u;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d       = state_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    out_result_d  = out_result_q;
    out_rd_addr_d = out_rd_addr_q;
    out_valid_d   = out_valid_q;
    out_we_d      = out_we_q;
    out_illegal_d = out_illegal_q;
    cnt_d         = cnt_q;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      if (state_q == EXEC) begin
        if (cnt_q == 4'd0) begin
          state_d       = DONE;
          out_result_d  = alu_rd;
          out_valid_d   = 1'b1;
          out_we_d      = (out_rd_addr_q != 5'd0);
          out_illegal_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end else if (state_q == DONE && out_ready && !accept) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end

      if (accept) begin
        out_rd_addr_d = in_instr[11:7];
        if (dec_illegal) begin
          // alu_* keep their previous values: nothing to execute
          state_d       = DONE;
          out_valid_d   = 1'b1;
          out_result_d  = '0;
          out_we_d      = 1'b0;
          out_illegal_d = 1'b1;
          cnt_d         = '0;
        end else begin
          state_d     = EXEC;
          out_valid_d = 1'b0;
          alu_op_d    = dec_op;
          alu_a_d     = dec_a;
          alu_b_d     = dec_b;
          cnt_d       = dec_mul ? 4'(MUL_LATENCY - 1) : 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_op_q      <= OP_ADD;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      out_result_q  <= '0;
      out_rd_addr_q <= '0;
      out_valid_q   <= 1'b0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      out_result_q  <= out_result_d;
      out_rd_addr_q <= out_rd_addr_d;
      out_valid_q   <= out_valid_d;
      out_we_q      <= out_we_d;
      out_illegal_q <= out_illegal_d;
      cnt_q         <= cnt_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign out_result  = out_result_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_we      = out_we_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_rs1_val = 32'h0;
  logic [31:0] in_rs2_val = 32'h0;
  logic        flush = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_rd;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;
  logic        out_we, out_illegal;

  int n_cmp = 0;
  int n_fail = 0;

  alu_issue_ctrl #(.DATAWIDTH(32), .MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .flush(flush), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_rd(alu_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd_addr(out_rd_addr), .out_we(out_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // combinational ALU the controller drives
  always_comb begin
    case (alu_op)
      4'h0:    alu_rd = alu_a << alu_b[4:0];
      4'h1:    alu_rd = alu_a >> alu_b[4:0];
      4'h2:    alu_rd = $signed(alu_a) >>> alu_b[4:0];
      4'h3:    alu_rd = alu_a + alu_b;
      4'h4:    alu_rd = alu_a - alu_b;
      4'h5:    alu_rd = alu_b;
      4'h6:    alu_rd = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'h7:    alu_rd = {31'b0, alu_a < alu_b};
      4'h8:    alu_rd = alu_a ^ alu_b;
      4'h9:    alu_rd = alu_a | alu_b;
      4'hA:    alu_rd = alu_a & alu_b;
      4'hB:    alu_rd = alu_a * alu_b;
      default: alu_rd = 32'h0;
    endcase
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [3:0]  op;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V semantics straight from the instruction word
  function automatic logic [31:0] arith(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                    input logic [31:0] b, output logic ill,
                                    output logic [31:0] res, output int lat);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    f3  = ins[14:12];
    f7  = ins[31:25];
    imm = {{20{ins[31]}}, ins[31:20]};
    ill = 1'b0;
    res = 32'h0;
    lat = 1;
    if (ins[6:0] == 7'b0110111) begin
      res = {ins[31:12], 12'h000};
    end else if (ins[6:0] == 7'b0110011) begin
      if (f7 == 7'h00)                    res = arith(f3, a, b, b[4:0]);
      else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
      else if (f7 == 7'h20 && f3 == 3'd5) res = $signed(a) >>> b[4:0];
      else if (f7 == 7'h01 && f3 == 3'd0) begin res = a * b; lat = MUL_LAT; end
      else ill = 1'b1;
    end else if (ins[6:0] == 7'b0010011) begin
      if (f3 == 3'd1 && f7 != 7'h00)                      ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20)                 res = $signed(a) >>> ins[24:20];
      else if (f3 == 3'd5 && f7 != 7'h00)                 ill = 1'b1;
      else                                                res = arith(f3, a, imm, ins[24:20]);
    end else begin
      ill = 1'b1;
    end
    if (ill) lat = 0;
  endfunction

  // issue one op; returns with its result on out_* (out_ready high completes it at the next edge)
  task automatic do_op(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       output logic ok, output int lat, output logic [3:0] op_t,
                       output logic [31:0] b_t);
    int w;
    in_instr = instr;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_t = alu_op;
    b_t = alu_b;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] exp_res, input logic exp_ill,
                          input int exp_lat);
    logic ok;
    int lat;
    logic [3:0] op_t;
    logic [31:0] b_t;
    logic [4:0] rd;
    rd = instr[11:7];
    do_op(instr, rs1, rs2, ok, lat, op_t, b_t);
    chk({tag, "_ready"}, 32'(ok), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, out_result, exp_res);
    chk({tag, "_rd"}, 32'(out_rd_addr), 32'(rd));
    chk({tag, "_we"}, 32'(out_we), 32'(!exp_ill && rd != 5'd0));
    chk({tag, "_ill"}, 32'(out_illegal), 32'(exp_ill));
  endtask

  initial begin
    vec_t vecs[13];
    logic ok, ill, seen;
    int lat, exp_lat;
    logic [3:0] op_t;
    logic [31:0] b_t, res, ins, a, b;
    logic [6:0] opc, f7;

    vecs[0]  = '{32'h002081B3, 32'd5, 32'd7, 32'd12, 5'd3, 1'b1, 1'b0, 4'h3, 1};
    vecs[1]  = '{32'h4040D293, 32'h80000010, 32'd0, 32'hF8000001, 5'd5, 1'b1, 1'b0, 4'h2, 1};
    vecs[2]  = '{32'h02208333, 32'd6, 32'd7, 32'd42, 5'd6, 1'b1, 1'b0, 4'hB, MUL_LAT};
    vecs[3]  = '{32'h123453B7, 32'd9, 32'd9, 32'h12345000, 5'd7, 1'b1, 1'b0, 4'h5, 1};
    vecs[4]  = '{32'h00002003, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 4'h0, 0};
    vecs[5]  = '{32'h00500013, 32'd10, 32'd0, 32'd15, 5'd0, 1'b0, 1'b0, 4'h3, 1};
    vecs[6]  = '{32'h40208433, 32'd3, 32'd5, 32'hFFFFFFFE, 5'd8, 1'b1, 1'b0, 4'h4, 1};
    vecs[7]  = '{32'h0020B4B3, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd9, 1'b1, 1'b0, 4'h7, 1};
    vecs[8]  = '{32'h0020A533, 32'hFFFFFFFF, 32'd1, 32'd1, 5'd10, 1'b1, 1'b0, 4'h6, 1};
    vecs[9]  = '{32'h40309593, 32'd1, 32'd1, 32'd0, 5'd11, 1'b0, 1'b1, 4'h0, 0};
    vecs[10] = '{32'h02209633, 32'd1, 32'd1, 32'd0, 5'd12, 1'b0, 1'b1, 4'h0, 0};
    vecs[11] = '{32'hFFF0F693, 32'h1234ABCD, 32'd0, 32'h1234ABCD, 5'd13, 1'b1, 1'b0, 4'hA, 1};
    vecs[12] = '{32'h4020D733, 32'h80000000, 32'h21, 32'hC0000000, 5'd14, 1'b1, 1'b0, 4'h2, 1};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_op", 32'(alu_op), 32'h3);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_rd", 32'(out_rd_addr), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_we", 32'(out_we), 32'h0);
    chk("rst_ill", 32'(out_illegal), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, ok, lat, op_t, b_t);
      chk($sformatf("vec%0d_ready", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      if (!vecs[i].ill) chk($sformatf("vec%0d_op", i), 32'(op_t), 32'(vecs[i].op));
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d_rd", i), 32'(out_rd_addr), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_we", i), 32'(out_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_ill", i), 32'(out_illegal), 32'(vecs[i].ill));
    end

    // srai operand b is the shift amount
    do_op(32'h4040D293, 32'h80000010, 32'hDEADBEEF, ok, lat, op_t, b_t);
    chk("srai_b", b_t, 32'd4);

    // randomized against the reference model
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    opc = 7'b0110011;
        2:       opc = 7'b0010011;
        3:       opc = 7'b0110111;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      ins = {f7, 18'($urandom), opc};
      a = $urandom;
      b = $urandom;
      ref_model(ins, a, b, ill, res, exp_lat);
      check_op($sformatf("rnd%0d_%08h", i, ins), ins, a, b, res, ill, exp_lat);
    end
    @(posedge clk); #1;

    // writeback stall: outputs held, no new accept
    out_ready = 1'b0;
    do_op(32'h123453B7, 32'd0, 32'd0, ok, lat, op_t, b_t);
    chk("stall_lat", 32'(lat), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_result", c), out_result, 32'h12345000);
      chk($sformatf("stall%0d_rd", c), 32'(out_rd_addr), 32'd7);
      chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_release_ready", 32'(in_ready), 32'd1);

    // illegal lands directly in DONE; a second illegal keeps out_valid high; then addi x0 back-to-back
    in_instr = 32'h00002003;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("ill1_valid", 32'(out_valid), 32'd1);
    chk("ill1_ill", 32'(out_illegal), 32'd1);
    chk("ill1_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("ill2_valid", 32'(out_valid), 32'd1);
    chk("ill2_we", 32'(out_we), 32'd0);
    in_instr = 32'h00500013;
    in_rs1_val = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid_low", 32'(out_valid), 32'd0);
    chk("b2b_alu_op", 32'(alu_op), 32'h3);
    @(posedge clk); #1;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_result", out_result, 32'd15);
    chk("b2b_we", 32'(out_we), 32'd0);
    chk("b2b_ill", 32'(out_illegal), 32'd0);
    @(posedge clk); #1;

    // reset one cycle into a MUL
    in_instr = 32'h02208333;
    in_rs1_val = 32'd6;
    in_rs2_val = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mulrst_op", 32'(alu_op), 32'hB);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mulrst_valid", 32'(out_valid), 32'd0);
    chk("mulrst_alu_op", 32'(alu_op), 32'h3);
    chk("mulrst_alu_a", alu_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mulrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (MUL_LAT + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mulrst_no_valid", 32'(seen), 32'd0);

    // flush together with in_valid: no accept
    in_instr = 32'h002081B3;
    in_rs1_val = 32'd5;
    in_rs2_val = 32'd7;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    seen = 1'b0;
    repeat (MUL_LAT + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_accept_no_valid", 32'(seen), 32'd0);
    chk("flush_accept_alu_op", 32'(alu_op), 32'h3);

    // flush mid-MUL
    in_instr = 32'h02208333;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    repeat (MUL_LAT + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_exec_no_valid", 32'(seen), 32'd0);
    chk("flush_exec_in_ready", 32'(in_ready), 32'd1);
    check_op("post_flush_mul", 32'h02208333, 32'd6, 32'd7, 32'd42, 1'b0, MUL_LAT);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
